reg_bank8: RTL and testbench
============================

// Module: reg_bank8
//
// PURPOSE
//   Eight-entry register bank that holds the operands selected by the downstream 8:1 read mux.
//   Exposes all entries as one packed bus; read selection happens downstream.
//   Provides a byte-enabled write port, a synchronous clear-all and a per-entry pending
//   (scoreboard) bitmap so the issue logic can detect read-after-write hazards.
//   Sits between the writeback stage (upstream) and the operand read muxes (downstream).
//
// PARAMETERS
//   WIDTH     32  data width per entry; must be a multiple of 8
//   ZERO_REG  1   1 = entry 0 is hardwired to zero and never pending; 0 = entry 0 is ordinary
//
// PORTS
//   clk        in   1              clock; all state updates on posedge
//   reset      in   1              synchronous, active-high reset
//   wr_en      in   1              write request this cycle
//   wr_addr    in   3              entry written
//   wr_data    in   WIDTH          write data
//   wr_be      in   WIDTH/8        byte enables; bit i covers wr_data[8i+7:8i]
//   clr_all    in   1              synchronous clear of all entries and the pending bitmap
//   pend_set   in   1              mark entry pend_addr as awaiting a write
//   pend_addr  in   3              entry marked pending
//   regs       out  [7:0][WIDTH]   packed contents; regs[n] is entry n
//   pending    out  8              pending[n]=1: entry n has an outstanding producer
//   hazard     out  1              combinational: pend_set && pending[pend_addr]
//
// BEHAVIOUR
//   - Reset (sync, active-high): every regs[n] = 0 and pending = 8'h00 on the next posedge.
//   - Priority on a posedge: reset > clr_all > (write, pend_set).
//   - clr_all behaves exactly like reset. It cancels any write or pend_set in the same cycle.
//   - Write: if wr_en, for each i with wr_be[i]=1, regs[wr_addr][8i+:8] <= wr_data[8i+:8].
//     Bytes whose enable is 0 are unchanged.
//   - Write latency: new data is visible on regs the cycle after the write edge. There is no
//     write-to-read bypass; any bypass is the consumer's responsibility.
//   - ZERO_REG=1:
//     - writes to entry 0 are dropped, so regs[0] stays 0;
//     - pend_set to entry 0 is ignored, so pending[0] stays 0;
//     - hazard is 0 whenever pend_addr=0.
//   - Pending clear: wr_en=1 clears pending[wr_addr]. This applies even when wr_be=0;
//     writeback completes with no data change.
//   - Pending set: pend_set=1 sets pending[pend_addr].
//   - Set and clear on the same entry in the same cycle: the set wins (a new producer issued),
//     so pending stays 1.
//   - Set and clear on different entries in the same cycle: both take effect.
//   - pend_set on an entry that is already pending: the bit stays 1 and hazard=1 that cycle.
//   - hazard is purely combinational from the current pending value and the current inputs.
//   - No other state. Writes have no back-pressure: one write per cycle is always accepted.
//
// TESTING
//   1. Assert reset for 2 cycles after random writes -> all regs = 0, pending = 8'h00,
//      hazard = 0.
//   2. wr_en=1, wr_addr=3, wr_data=32'hAA0ED000, wr_be=4'hF -> regs[3] = 32'hAA0ED000 next
//      cycle. Then wr_data=32'h11223344, wr_be=4'b0101 -> regs[3] = 32'hAA22D044.
//   3. ZERO_REG=1: wr_en to addr 0 with 32'hFFFFFFFF, and pend_set addr 0 -> regs[0] = 0,
//      pending[0] = 0, hazard = 0.
//   4. pend_set addr 5 -> pending = 8'h20. Next cycle pend_set addr 5 -> hazard = 1.
//      Then wr_en addr 5 with wr_be=0 -> pending = 8'h00 and regs[5] unchanged.
//   5. Same cycle: pend_set addr 2 and wr_en addr 2 while pending[2]=1 -> pending[2] stays 1
//      and regs[2] is updated. Same cycle: pend_set 4 with wr_en 6 -> pending[4]=1, pending[6]=0.
//   6. Fill entries 1-7 with 32'h0A09030A and set pending=8'hFE. Then clr_all together with
//      wr_en addr 1 -> every entry 0 and pending 0; the write is lost.

Source files
------------

// File: rtl/reg_bank8.sv
// Eight-entry register bank with byte-enabled writes, clear-all
// and a per-entry pending bitmap for read-after-write hazard detection.
module reg_bank8 #(
   parameter int WIDTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [2:0]            wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [WIDTH/8-1:0]    wr_be,
   input  logic                  clr_all,
   input  logic                  pend_set,
   input  logic [2:0]            pend_addr,
   output logic [7:0][WIDTH-1:0] regs,
   output logic [7:0]            pending,
   output logic                  hazard
);

   localparam int NB = WIDTH / 8;

   logic [7:0][WIDTH-1:0] mem;
   logic [7:0]            pend_q;
   logic [7:0]            pend_d;
   logic                  wr_ok;
   logic                  set_ok;

   // With ZERO_REG, entry 0 ignores both writes and producer marks.
   assign wr_ok  = wr_en && !(ZERO_REG != 0 && wr_addr == 3'd0);
   assign set_ok = pend_set && !(ZERO_REG != 0 && pend_addr == 3'd0);

   always_comb begin
      pend_d = pend_q;
      if (wr_en) pend_d[wr_addr] = 1'b0;
      if (set_ok) pend_d[pend_addr] = 1'b1;
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset || clr_all) begin
         mem    <= '0;
         pend_q <= '0;
      end else begin
         if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
               if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
         pend_q <= pend_d;
      end
   end

   assign regs    = mem;
   assign pending = pend_q;
   assign hazard  = set_ok && pend_q[pend_addr];

endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: directed vector table,
// hand sequences for reset/clear, and randomized model comparison.
module tb_reg_bank8;

   logic            clk = 1'b0;
   logic            reset;
   logic            wr_en;
   logic [2:0]      wr_addr;
   logic [31:0]     wr_data;
   logic [3:0]      wr_be;
   logic            clr_all;
   logic            pend_set;
   logic [2:0]      pend_addr;
   logic [7:0][31:0] regs;
   logic [7:0]      pending;
   logic            hazard;

   int checks = 0;
   int errors = 0;

   logic [31:0] mreg [8];
   logic [7:0]  mp;

   reg_bank8 #(.WIDTH(32), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .clr_all(clr_all),
      .pend_set(pend_set), .pend_addr(pend_addr), .regs(regs),
      .pending(pending), .hazard(hazard)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        ps;
      logic [2:0]  pa;
      logic        hz;
      logic [2:0]  ca;
      logic [31:0] cv;
      logic [7:0]  cp;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      reset = 0; clr_all = 0; wr_en = 0; wr_addr = 0;
      wr_data = 0; wr_be = 0; pend_set = 0; pend_addr = 0;
   endtask

   task automatic check_all(input string name, input logic [31:0] v,
                            input logic [7:0] p);
      for (int n = 0; n < 8; n++)
         check($sformatf("%s regs[%0d]", name, n), regs[n], v);
      check({name, " pending"}, {24'h0, pending}, {24'h0, p});
   endtask

   // Reference model: spec rules applied directly on arrays.
   task automatic model_step();
      logic [7:0] np;
      if (reset || clr_all) begin
         for (int n = 0; n < 8; n++) mreg[n] = 0;
         mp = 0;
      end else begin
         np = mp;
         if (wr_en && wr_addr != 0)
            for (int i = 0; i < 4; i++)
               if (wr_be[i]) mreg[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
         if (wr_en) np[wr_addr] = 0;
         if (pend_set && pend_addr != 0) np[pend_addr] = 1;
         mp = np;
      end
   endtask

   initial begin
      idle();
      for (int n = 0; n < 8; n++) mreg[n] = 0;
      mp = 0;

      // Random writes, then reset held for two cycles
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         wr_en = 1; wr_addr = 3'($urandom_range(7));
         wr_data = $urandom; wr_be = 4'hF;
         pend_set = 1; pend_addr = 3'($urandom_range(7));
      end
      @(negedge clk);
      idle(); reset = 1;
      repeat (2) @(negedge clk);
      check_all("reset", 32'h0, 8'h00);
      check("reset hazard", {31'h0, hazard}, 32'h0);
      reset = 0;

      tbl[0]  = '{1'b1, 3'd3, 32'hAA0ED000, 4'hF, 1'b0, 3'd0, 1'b0, 3'd3, 32'hAA0ED000, 8'h00};
      tbl[1]  = '{1'b1, 3'd3, 32'h11223344, 4'h5, 1'b0, 3'd0, 1'b0, 3'd3, 32'hAA22D044, 8'h00};
      tbl[2]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 3'd0, 1'b0, 3'd0, 32'h00000000, 8'h00};
      tbl[3]  = '{1'b1, 3'd5, 32'h12345678, 4'hF, 1'b0, 3'd0, 1'b0, 3'd5, 32'h12345678, 8'h00};
      tbl[4]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd5, 1'b0, 3'd5, 32'h12345678, 8'h20};
      tbl[5]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd5, 1'b1, 3'd5, 32'h12345678, 8'h20};
      tbl[6]  = '{1'b1, 3'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 3'd0, 1'b0, 3'd5, 32'h12345678, 8'h00};
      tbl[7]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd2, 1'b0, 3'd2, 32'h00000000, 8'h04};
      tbl[8]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd6, 1'b0, 3'd6, 32'h00000000, 8'h44};
      tbl[9]  = '{1'b1, 3'd2, 32'hCAFEBABE, 4'hF, 1'b1, 3'd2, 1'b1, 3'd2, 32'hCAFEBABE, 8'h44};
      tbl[10] = '{1'b1, 3'd6, 32'hDEADBEEF, 4'h3, 1'b1, 3'd4, 1'b0, 3'd6, 32'h0000BEEF, 8'h14};

      for (int v = 0; v < 11; v++) begin
         @(negedge clk);
         idle();
         wr_en = tbl[v].wr; wr_addr = tbl[v].a; wr_data = tbl[v].d;
         wr_be = tbl[v].be; pend_set = tbl[v].ps; pend_addr = tbl[v].pa;
         #1;
         check($sformatf("vec%0d hazard", v), {31'h0, hazard}, {31'h0, tbl[v].hz});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d regs[%0d]", v, tbl[v].ca), regs[tbl[v].ca], tbl[v].cv);
         check($sformatf("vec%0d pending", v), {24'h0, pending}, {24'h0, tbl[v].cp});
      end

      // Fill 1..7, mark all pending, then clr_all beats a same-cycle write
      for (int n = 1; n < 8; n++) begin
         @(negedge clk);
         idle(); wr_en = 1; wr_addr = 3'(n);
         wr_data = 32'h0A09030A; wr_be = 4'hF;
      end
      for (int n = 1; n < 8; n++) begin
         @(negedge clk);
         idle(); pend_set = 1; pend_addr = 3'(n);
      end
      @(negedge clk);
      idle();
      check("fill regs[7]", regs[7], 32'h0A09030A);
      check("fill pending", {24'h0, pending}, 32'h000000FE);
      clr_all = 1; wr_en = 1; wr_addr = 3'd1;
      wr_data = 32'h55555555; wr_be = 4'hF;
      @(negedge clk);
      idle();
      check_all("clr_all", 32'h0, 8'h00);

      // Randomized run against the model (state is all-zero here)
      for (int n = 0; n < 8; n++) mreg[n] = 0;
      mp = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         reset     = ($urandom_range(59) == 0);
         clr_all   = ($urandom_range(39) == 0);
         wr_en     = 1'($urandom_range(1));
         wr_addr   = 3'($urandom_range(7));
         wr_data   = $urandom;
         wr_be     = 4'($urandom_range(15));
         pend_set  = 1'($urandom_range(1));
         pend_addr = 3'($urandom_range(7));
         #1;
         check($sformatf("rnd%0d hazard", k), {31'h0, hazard},
               {31'h0, pend_set && pend_addr != 0 && mp[pend_addr]});
         model_step();
         @(posedge clk);
         #1;
         for (int n = 0; n < 8; n++)
            check($sformatf("rnd%0d regs[%0d]", k, n), regs[n], mreg[n]);
         check($sformatf("rnd%0d pending", k), {24'h0, pending}, {24'h0, mp});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
